// File: rtl/uart_rx_if.sv
// uart_rx_if -- receive-side bus between uart_rx and its consumer.
//
// Signals:
//   rd_en      consumer -> rx   pop the FIFO head
//   clr_err    consumer -> rx   clear sticky error flags
//   rx_data    rx -> consumer   FIFO head byte, first-word-fall-through
//   rx_valid   rx -> consumer   FIFO not empty
//   rx_count   rx -> consumer   FIFO occupancy
//   frame_err  rx -> consumer   sticky, stop bit sampled low
//   overrun    rx -> consumer   sticky, byte lost to a full FIFO
//   parity_err rx -> consumer   sticky, parity mismatch
//
// Modports: master = uart_rx side, slave = consumer side.
interface uart_rx_if #(
    parameter int FIFO_DEPTH = 4
) ();
    logic                          rd_en;
    logic                          clr_err;
    logic [7:0]                    rx_data;
    logic                          rx_valid;
    logic [$clog2(FIFO_DEPTH):0]   rx_count;
    logic                          frame_err;
    logic                          overrun;
    logic                          parity_err;

    modport master (
        input  rd_en, clr_err,
        output rx_data, rx_valid, rx_count, frame_err, overrun, parity_err
    );

    modport slave (
        output rd_en, clr_err,
        input  rx_data, rx_valid, rx_count, frame_err, overrun, parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver with a first-word-fall-through FIFO.
//
// Ports:
//   clk   single clock, posedge
//   rst   synchronous reset, active-high
//   rx    asynchronous serial line, idle high
//   bus   uart_rx_if.master: rd_en/clr_err in; rx_data, rx_valid, rx_count,
//         frame_err, overrun, parity_err out
//
// Parameters: CLKS_PER_BIT (>= 4), FIFO_DEPTH (power of two, >= 2).
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames (even parity);
// otherwise frames are 8N1 and parity_err is tied low.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a falling edge on the synchronized line
// START  | timing to mid start bit; a high sample there is a glitch
// DATA   | sampling 8 data bits LSB-first, one per CLKS_PER_BIT
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then push or flag a framing error
module uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    uart_rx_if.master  bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic             rx_s1, rx_s2, rx_d;
    logic [1:0]       sync_ok;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] count;
    logic             frame_err_q, overrun_q, parity_err_q;

    logic stop_tick, push, push_ok, pop, frame_set, overrun_set, parity_set;

    assign stop_tick = (state == STOP) && (cnt == BIT_LAST);
    assign frame_set = stop_tick && !rx_s2;

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    assign parity_set = (state == PARITY) && (cnt == BIT_LAST) && ((^shift) ^ rx_s2);
    assign push       = stop_tick && rx_s2 && !par_bad;
`else
    assign parity_set = 1'b0;
    assign push       = stop_tick && rx_s2;
`endif

    assign pop         = bus.rd_en && (count != '0);
    assign push_ok     = push && ((count != OCC_FULL) || pop);
    assign overrun_set = push && (count == OCC_FULL) && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_d    <= 1'b0;
            sync_ok <= 2'b00;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            // The synchronizer resets to 1, which is not a real observation of
            // the line; rx_d only reports high once rx_s2 carries sampled data,
            // so a line held low through reset never looks like a start edge.
            sync_ok <= {sync_ok[0], 1'b1};
            rx_d    <= rx_s2 & sync_ok[1];

            case (state)
                IDLE: begin
                    if (rx_d && !rx_s2) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s2) begin
                            state   <= DATA;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bad <= (^shift) ^ rx_s2;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    state <= IDLE;
`endif
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new error event beats a same-cycle clear.
            frame_err_q  <= frame_set   || (frame_err_q  && !bus.clr_err);
            overrun_q    <= overrun_set || (overrun_q    && !bus.clr_err);
            parity_err_q <= parity_set  || (parity_err_q && !bus.clr_err);
        end
    end

    assign bus.rx_valid   = (count != '0);
    assign bus.rx_data    = (count != '0) ? mem[rd_ptr] : 8'h00;
    assign bus.rx_count   = count;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.parity_err = parity_err_q;
endmodule
